// File: rtl/ring_osc_counter.sv
// Ring oscillator frequency counter: gates the adder ring on, waits a settle time,
// then counts synchronized rising edges of a ring tap over a clk-cycle window.
module ring_osc_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SETTLE_W    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic [SETTLE_W-1:0] settle_len,
  input  logic                ring_in,
  output logic                osc_enable,
  output logic                busy,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  output logic                overflow
);

  localparam int TIMER_W = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   count_valid_q, count_valid_d;
  logic                   osc_enable_q, osc_enable_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_pulse;

  // The synchronizer and edge detector run in every state so the pipeline is
  // always primed; only pulses landing in COUNT cycles are accumulated.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ring_in};
    prev_d     = sync_q[SYNC_STAGES-1];
    edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    gate_d        = gate_q;
    edge_cnt_d    = edge_cnt_q;
    sat_d         = sat_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;
    osc_enable_d  = osc_enable_q;
    busy_d        = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          gate_d     = gate_len;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          if (settle_len != '0) begin
            state_d      = SETTLE;
            timer_d      = TIMER_W'(settle_len);
            osc_enable_d = 1'b1;
            busy_d       = 1'b1;
          end else if (gate_len != '0) begin
            state_d      = COUNT;
            timer_d      = TIMER_W'(gate_len);
            osc_enable_d = 1'b1;
            busy_d       = 1'b1;
          end else begin
            state_d      = DONE;
            osc_enable_d = 1'b0;
            busy_d       = 1'b0;
          end
        end
      end

      // timer holds the number of cycles left in the phase, including this one
      SETTLE: begin
        if (timer_q == TIMER_W'(1)) begin
          if (gate_q != '0) begin
            state_d = COUNT;
            timer_d = TIMER_W'(gate_q);
          end else begin
            state_d      = DONE;
            timer_d      = '0;
            osc_enable_d = 1'b0;
            busy_d       = 1'b0;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      COUNT: begin
        if (edge_pulse) begin
          if (edge_cnt_q == {CNT_W{1'b1}}) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (timer_q == TIMER_W'(1)) begin
          state_d      = DONE;
          timer_d      = '0;
          osc_enable_d = 1'b0;
          busy_d       = 1'b0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      DONE: begin
        count_d       = edge_cnt_q;
        overflow_d    = sat_q;
        count_valid_d = 1'b1;
        osc_enable_d  = 1'b0;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        state_d      = IDLE;
        osc_enable_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      gate_q        <= '0;
      edge_cnt_q    <= '0;
      sat_q         <= 1'b0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
      osc_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      sync_q        <= '0;
      prev_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      sat_q         <= sat_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      count_valid_q <= count_valid_d;
      osc_enable_q  <= osc_enable_d;
      busy_q        <= busy_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
    end
  end

  assign osc_enable  = osc_enable_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

endmodule
